// File: rtl/bch_pkg.sv
// Shared constants, types and the GF(2) LFSR step for the BCH(15,7) encoder.
// Generator g(x)=x^8+x^7+x^6+x^4+1; bit i of GEN_POLY is the x^i coefficient.
package bch_pkg;

  localparam int N  = 15;
  localparam int K  = 7;
  localparam int NK = N - K;

  localparam logic [NK:0] GEN_POLY = 9'h1D1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } enc_state_t;

  typedef logic [NK-1:0] parity_t;

  // One division step: feedback is the incoming bit XOR the top remainder bit.
  function automatic parity_t lfsr_step(input parity_t r, input logic b);
    logic u;
    u = b ^ r[NK-1];
    return {r[NK-2:0], 1'b0} ^ (u ? GEN_POLY[NK-1:0] : '0);
  endfunction

endpackage

// File: rtl/bch_serial_encoder_if.sv
// Message-in / codeword-out valid/ready bus of the BCH(15,7) encoder.
// The slave modport is the encoder; the master modport is the surrounding logic.
interface bch_serial_encoder_if
  import bch_pkg::*;
;
  logic         msg_valid;
  logic         msg_ready;
  logic [K-1:0] msg_data;
  logic         cw_valid;
  logic         cw_ready;
  logic [N-1:0] cw_data;

  modport slave (
    input  msg_valid,
    input  msg_data,
    output msg_ready,
    output cw_valid,
    input  cw_ready,
    output cw_data
  );

  modport master (
    output msg_valid,
    output msg_data,
    input  msg_ready,
    input  cw_valid,
    output cw_ready,
    input  cw_data
  );

endinterface

// File: rtl/bch_parity_lfsr.sv
// Parity remainder register: divides the serial message by g(x), MSB first.
// clear wins over step_en so a fresh message always starts from r=0.
module bch_parity_lfsr
  import bch_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clear,
  input  logic    step_en,
  input  logic    bit_in,
  output parity_t parity
);

  parity_t parity_q;
  parity_t parity_d;

  always_comb begin
    parity_d = parity_q;
    if (clear) begin
      parity_d = '0;
    end else if (step_en) begin
      parity_d = lfsr_step(parity_q, bit_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= '0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;

endmodule

// File: rtl/bch_serial_encoder.sv
// Systematic BCH(15,7) encoder: latch a message, shift it through the parity
// LFSR one bit per clock, then hold {msg, parity} until the codeword is taken.
module bch_serial_encoder
  import bch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  bch_serial_encoder_if.slave  bus,
  output logic                 busy
);

  localparam int                CNT_W = $clog2(K);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(K - 1);

  enc_state_t       state_q, state_d;
  logic [K-1:0]     msg_q, msg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cw_valid_q, cw_valid_d;
  logic [N-1:0]     cw_data_q, cw_data_d;

  logic    msg_ready_c;
  logic    accept;
  logic    step_en;
  logic    cur_bit;
  parity_t parity;

  // HOLD forwards cw_ready so a retiring codeword and a new message share one edge;
  // rst_n gates it so nothing is offered while the block is held in reset.
  assign msg_ready_c = rst_n && !clr &&
                       ((state_q == IDLE) || ((state_q == HOLD) && bus.cw_ready));
  assign accept      = bus.msg_valid && msg_ready_c;
  assign step_en     = (state_q == SHIFT) && !clr;
  assign cur_bit     = msg_q[LAST - cnt_q];

  bch_parity_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .step_en (step_en),
    .bit_in  (cur_bit),
    .parity  (parity)
  );

  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    cnt_d      = cnt_q;
    cw_valid_d = cw_valid_q;
    cw_data_d  = cw_data_q;
    if (clr) begin
      state_d    = IDLE;
      cw_valid_d = 1'b0;
      cnt_d      = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            msg_d   = bus.msg_data;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // Register the codeword with the final step folded in, so it is
            // valid on the same edge the FSM enters HOLD.
            state_d    = HOLD;
            cw_valid_d = 1'b1;
            cw_data_d  = {msg_q, lfsr_step(parity, cur_bit)};
          end
        end
        HOLD: begin
          if (bus.cw_ready) begin
            cw_valid_d = 1'b0;
            if (accept) begin
              msg_d   = bus.msg_data;
              cnt_d   = '0;
              state_d = SHIFT;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d    = IDLE;
          cw_valid_d = 1'b0;
          cnt_d      = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      msg_q      <= '0;
      cnt_q      <= '0;
      cw_valid_q <= 1'b0;
      cw_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      msg_q      <= msg_d;
      cnt_q      <= cnt_d;
      cw_valid_q <= cw_valid_d;
      cw_data_q  <= cw_data_d;
    end
  end

  assign bus.msg_ready = msg_ready_c;
  assign bus.cw_valid  = cw_valid_q;
  assign bus.cw_data   = cw_data_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_bch_serial_encoder.sv
// Directed and randomised bench for bch_serial_encoder with a
// long-division reference model of c(x) = m(x)x^8 + (m(x)x^8 mod g(x)).
module tb_bch_serial_encoder;
  import bch_pkg::*;

  logic clk;
  logic rst_n;
  logic clr;
  logic busy;
  int   checks;
  int   failures;

  bch_serial_encoder_if intf();

  bch_serial_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (intf.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Remainder of a 15-bit polynomial divided by g(x), by schoolbook long division.
  function automatic logic [7:0] poly_mod(input logic [14:0] p);
    logic [14:0] rem;
    logic [14:0] g;
    rem = p;
    g   = 15'(GEN_POLY);
    for (int i = 14; i >= 8; i--) begin
      if (rem[i]) rem = rem ^ (g << (i - 8));
    end
    return rem[7:0];
  endfunction

  function automatic logic [14:0] ref_cw(input logic [6:0] m);
    logic [14:0] shifted;
    shifted = {m, 8'h00};
    return shifted | {7'h00, poly_mod(shifted)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept one message from IDLE with cw_ready=1 and check latency and codeword.
  task automatic do_msg(input logic [6:0] m, input logic [14:0] exp, input string tag);
    int lat;
    check_eq({tag, "_rdy"}, 32'(intf.msg_ready), 32'd1);
    intf.msg_data  = m;
    intf.msg_valid = 1'b1;
    tick();
    intf.msg_valid = 1'b0;
    intf.msg_data  = ~m;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!intf.cw_valid && lat < 30) begin
      tick();
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd7);
    check_eq({tag, "_cw"}, 32'(intf.cw_data), 32'(exp));
    tick();
    check_eq({tag, "_retire"}, 32'(intf.cw_valid), 32'd0);
  endtask

  // Accept 7'h40, run three steps (counter=3), leaving the bench mid-SHIFT.
  task automatic start_and_shift3;
    intf.msg_data  = 7'h40;
    intf.msg_valid = 1'b1;
    tick();
    intf.msg_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic watch_no_cw(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (intf.cw_valid) pulses++;
      tick();
    end
    check_eq(tag, 32'(pulses), 32'd0);
  endtask

  logic [6:0]  b2b_msg [3];
  logic [14:0] b2b_cw  [3];

  initial begin
    int          idx, got, cyc, last_cyc, waitc;
    bit          take_cw, take_msg;
    logic [6:0]  m;
    logic [14:0] first_cw;

    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    clr            = 1'b0;
    intf.msg_valid = 1'b0;
    intf.msg_data  = '0;
    intf.cw_ready  = 1'b1;
    b2b_msg = '{7'h01, 7'h40, 7'h7F};
    b2b_cw  = '{15'h01D1, 15'h40E8, 15'h7FFF};

    // Reset with random inputs toggling.
    for (int i = 0; i < 5; i++) begin
      intf.msg_valid = 1'($urandom_range(0, 1));
      intf.msg_data  = 7'($urandom);
      intf.cw_ready  = 1'($urandom_range(0, 1));
      tick();
      check_eq("rst_cw_valid", 32'(intf.cw_valid), 32'd0);
      check_eq("rst_cw_data", 32'(intf.cw_data), 32'd0);
      check_eq("rst_msg_ready", 32'(intf.msg_ready), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
    end
    intf.msg_valid = 1'b0;
    intf.cw_ready  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("idle_msg_ready", 32'(intf.msg_ready), 32'd1);
    clr = 1'b1;
    #1;
    check_eq("clr_blocks_ready", 32'(intf.msg_ready), 32'd0);
    clr = 1'b0;
    tick();

    // Known vectors.
    do_msg(7'h01, 15'h01D1, "v01");
    do_msg(7'h40, 15'h40E8, "v40");
    do_msg(7'h7F, 15'h7FFF, "v7f");
    do_msg(7'h00, 15'h0000, "v00");
    check_eq("idle_hold_cw", 32'(intf.cw_data), 32'h0000);

    // Backpressure with a pending message.
    intf.cw_ready  = 1'b0;
    intf.msg_data  = 7'h40;
    intf.msg_valid = 1'b1;
    tick();
    intf.msg_data = 7'h01;
    waitc = 0;
    while (!intf.cw_valid && waitc < 30) begin
      tick();
      waitc++;
    end
    check_eq("bp_lat", 32'(waitc), 32'd7);
    for (int i = 0; i < 20; i++) begin
      check_eq("bp_valid", 32'(intf.cw_valid), 32'd1);
      check_eq("bp_data", 32'(intf.cw_data), 32'h40E8);
      check_eq("bp_msg_ready", 32'(intf.msg_ready), 32'd0);
      tick();
    end
    intf.cw_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(intf.msg_ready), 32'd1);
    tick();
    intf.msg_valid = 1'b0;
    check_eq("bp_next_busy", 32'(busy), 32'd1);
    check_eq("bp_next_valid", 32'(intf.cw_valid), 32'd0);
    waitc = 0;
    while (!intf.cw_valid && waitc < 30) begin
      tick();
      waitc++;
    end
    check_eq("bp_next_lat", 32'(waitc), 32'd7);
    check_eq("bp_next_cw", 32'(intf.cw_data), 32'h01D1);
    tick();

    // Back-to-back stream.
    idx = 0; got = 0; cyc = 0; last_cyc = 0;
    intf.msg_data  = b2b_msg[0];
    intf.msg_valid = 1'b1;
    while (got < 3 && cyc < 100) begin
      take_cw  = intf.cw_valid && intf.cw_ready;
      take_msg = intf.msg_valid && intf.msg_ready;
      if (take_cw) begin
        check_eq("b2b_cw", 32'(intf.cw_data), 32'(b2b_cw[got]));
        if (got > 0) check_eq("b2b_spacing", 32'(cyc - last_cyc), 32'd8);
        last_cyc = cyc;
        got++;
      end
      tick();
      cyc++;
      if (take_msg) begin
        idx++;
        if (idx < 3) intf.msg_data = b2b_msg[idx];
        else intf.msg_valid = 1'b0;
      end
    end
    check_eq("b2b_count", 32'(got), 32'd3);
    watch_no_cw("b2b_no_dup", 12);

    // Synchronous abort mid-SHIFT.
    start_and_shift3();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_busy", 32'(busy), 32'd0);
    watch_no_cw("clr_no_cw", 15);
    do_msg(7'h01, 15'h01D1, "clr_after");

    // Asynchronous reset pulse mid-SHIFT, clear of any clock edge.
    start_and_shift3();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_ready", 32'(intf.msg_ready), 32'd0);
    check_eq("arst_cw_data", 32'(intf.cw_data), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    watch_no_cw("arst_no_cw", 15);
    do_msg(7'h01, 15'h01D1, "arst_after");

    // Random messages with random backpressure.
    for (int n = 0; n < 1000; n++) begin
      m              = 7'($urandom);
      intf.cw_ready  = 1'b0;
      intf.msg_data  = m;
      intf.msg_valid = 1'b1;
      waitc = 0;
      while (!intf.msg_ready && waitc < 50) begin
        tick();
        waitc++;
      end
      tick();
      intf.msg_valid = 1'b0;
      intf.msg_data  = 7'($urandom);
      waitc = 0;
      while (!intf.cw_valid && waitc < 30) begin
        tick();
        waitc++;
      end
      first_cw = intf.cw_data;
      waitc = 0;
      intf.cw_ready = 1'($urandom_range(0, 1));
      #1;
      while (!(intf.cw_valid && intf.cw_ready) && waitc < 50) begin
        tick();
        waitc++;
        intf.cw_ready = 1'($urandom_range(0, 1));
        #1;
      end
      check_eq("rnd_cw", 32'(intf.cw_data), 32'(ref_cw(m)));
      check_eq("rnd_stable_syn", {16'(first_cw ^ intf.cw_data), 8'h00, poly_mod(intf.cw_data)}, 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
